// File: rtl/pwm_compare_nch_if.sv
// Carrier, compare, shadow-configuration and gate-output bundle of the multi-channel PWM compare stage.
// The master drives carriers and configuration; the slave returns the gate outputs and status.
interface pwm_compare_nch_if #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 8,
    parameter int NCH   = 3
);
    logic [CNT_W-1:0]     carrier;
    logic [CNT_W-1:0]     carrier_master;
    logic [NCH*CNT_W-1:0] compare;
    logic [NCH-1:0]       carrsel;
    logic [NCH*DT_W-1:0]  dtime_a;
    logic [NCH*DT_W-1:0]  dtime_b;
    logic [NCH-1:0]       logic_a;
    logic [NCH-1:0]       logic_b;
    logic [NCH-1:0]       dt_onoff;
    logic                 pwm_onoff;
    logic                 maskevent;
    logic                 fault;
    logic                 fault_clr;
    logic [NCH-1:0]       pwmout_a;
    logic [NCH-1:0]       pwmout_b;
    logic                 fault_latched;
    logic                 load_ack;

    modport master (
        output carrier, carrier_master, compare, carrsel, dtime_a, dtime_b,
               logic_a, logic_b, dt_onoff, pwm_onoff, maskevent, fault, fault_clr,
        input  pwmout_a, pwmout_b, fault_latched, load_ack
    );

    modport slave (
        input  carrier, carrier_master, compare, carrsel, dtime_a, dtime_b,
               logic_a, logic_b, dt_onoff, pwm_onoff, maskevent, fault, fault_clr,
        output pwmout_a, pwmout_b, fault_latched, load_ack
    );
endinterface

// File: rtl/pwm_compare_nch.sv
// NCH complementary PWM channels: shadowed compare, per-edge dead time, polarity, latched fault shutdown.
// Carrier to gate output in 2 cycles (raw register, then ia/ib register); no backpressure.
module pwm_compare_nch #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 8,
    parameter int NCH   = 3
) (
    input logic              clk_i,
    input logic              rst_i,
    pwm_compare_nch_if.slave bus_if
);
    logic [NCH*CNT_W-1:0] cmp_q;
    logic [NCH*DT_W-1:0]  dta_q;
    logic [NCH*DT_W-1:0]  dtb_q;
    logic [NCH-1:0]       la_q;
    logic [NCH-1:0]       lb_q;
    logic [NCH-1:0]       dten_q;
    logic                 fault_q, fault_d;
    logic                 ack_q, ack_d;
    logic                 load_en;

    // Free-running copy while PWM is off; only maskevent updates a running PWM.
    assign load_en = ~bus_if.pwm_onoff | bus_if.maskevent;
    assign ack_d   = bus_if.pwm_onoff & bus_if.maskevent;

    always_comb begin
        fault_d = fault_q;
        if (bus_if.fault) begin
            fault_d = 1'b1;
        end else if (bus_if.fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_q   <= '0;
            dta_q   <= '0;
            dtb_q   <= '0;
            la_q    <= '1;
            lb_q    <= '1;
            dten_q  <= '0;
            fault_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            if (load_en) begin
                cmp_q  <= bus_if.compare;
                dta_q  <= bus_if.dtime_a;
                dtb_q  <= bus_if.dtime_b;
                la_q   <= bus_if.logic_a;
                lb_q   <= bus_if.logic_b;
                dten_q <= bus_if.dt_onoff;
            end
            fault_q <= fault_d;
            ack_q   <= ack_d;
        end
    end

    assign bus_if.fault_latched = fault_q;
    assign bus_if.load_ack      = ack_q;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [CNT_W-1:0] sel;
        logic [CNT_W-1:0] cmp_n;
        logic [DT_W-1:0]  dta_n;
        logic [DT_W-1:0]  dtb_n;
        logic [DT_W-1:0]  cnt_base;
        logic             en;
        logic             raw_q, raw_d;
        logic             rawp_q;
        logic             ia_q, ia_d;
        logic             ib_q, ib_d;
        logic [DT_W-1:0]  cnt_q, cnt_d;

        assign cmp_n    = cmp_q[n*CNT_W +: CNT_W];
        assign dta_n    = dta_q[n*DT_W +: DT_W];
        assign dtb_n    = dtb_q[n*DT_W +: DT_W];
        assign sel      = bus_if.carrsel[n] ? bus_if.carrier_master : bus_if.carrier;
        assign en       = bus_if.pwm_onoff & ~fault_q;
        assign raw_d    = en & (sel < cmp_n);
        // A raw toggle restarts the delay for the new edge, cancelling any pending opposite rise.
        assign cnt_base = (raw_q != rawp_q) ? '0 : cnt_q;

        always_comb begin
            ia_d  = 1'b0;
            ib_d  = 1'b0;
            cnt_d = '0;
            if (en) begin
                if (!dten_q[n]) begin
                    ia_d = raw_q;
                    ib_d = ~raw_q;
                end else if (raw_q) begin
                    if (ia_q || cnt_base == dta_n) begin
                        ia_d = 1'b1;
                    end else begin
                        cnt_d = cnt_base + 1'b1;
                    end
                end else begin
                    if (ib_q || cnt_base == dtb_n) begin
                        ib_d = 1'b1;
                    end else begin
                        cnt_d = cnt_base + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                raw_q  <= 1'b0;
                rawp_q <= 1'b0;
                ia_q   <= 1'b0;
                ib_q   <= 1'b0;
                cnt_q  <= '0;
            end else begin
                raw_q  <= raw_d;
                rawp_q <= raw_q;
                ia_q   <= ia_d;
                ib_q   <= ib_d;
                cnt_q  <= cnt_d;
            end
        end

        assign bus_if.pwmout_a[n] = la_q[n] ? ia_q : ~ia_q;
        assign bus_if.pwmout_b[n] = lb_q[n] ? ib_q : ~ib_q;
    end
endmodule

// File: doc/pwm_compare_nch.md
# pwm_compare_nch

Parametrised multi-channel successor of the 16-bit compare/dead-time block: NCH complementary PWM channels with configurable counter and dead-time widths. Each channel has its own shadowed compare, dead times, polarity and dead-time enable, and selects between a local and a master carrier. A latched fault shutdown forces every output inactive. Sits between the carrier generators and the gate-drive pins, driven by the AXI4-Lite register bank.

## Interface
Parameters:
- CNT_W, 16, carrier/compare width
- DT_W, 8, dead-time counter width
- NCH, 3, number of channels (1..8)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- carrier  in  CNT_W  local carrier count
- carrier_master  in  CNT_W  master carrier count
- compare  in  NCH*CNT_W  per-channel compare value, channel n at [n*CNT_W +: CNT_W]
- carrsel  in  NCH  1 = use carrier_master, 0 = use carrier
- dtime_a, dtime_b  in  NCH*DT_W  rising-edge delay in cycles for the A and B outputs
- logic_a, logic_b  in  NCH  1 = active-high output, 0 = active-low
- dt_onoff  in  NCH  per-channel dead-time enable
- pwm_onoff  in  1  global PWM enable
- maskevent  in  1  one-cycle shadow-load strobe
- fault  in  1  fault request, level
- fault_clr  in  1  fault-clear request, level
- pwmout_a, pwmout_b  out  NCH  gate outputs
- fault_latched  out  1  fault state
- load_ack  out  1  one-cycle pulse after each shadow load

## Operation
- Shadow set per channel: compare, dtime_a, dtime_b, logic_a, logic_b, dt_onoff.
  - pwm_onoff=0: active copy loads every cycle.
  - pwm_onoff=1: active copy loads only on cycles with maskevent=1.
  - Reset values: logic_* = 1, all other fields 0.
- load_ack is registered: 1 in the cycle after any cycle where a load occurred with pwm_onoff=1.
- Comparator, registered: raw[n] = pwm_onoff & (sel_carrier < cmp_active[n]), unsigned.
  - cmp=0 gives raw=0 for all carrier values.
  - cmp > every carrier value gives raw=1.
  - Carrier wrap needs no special handling.
- Dead time, per channel, registered state ia/ib.
  - dt_onoff=0: ia=raw, ib=~raw & pwm_onoff.
  - dt_onoff=1, raw 0→1: ib←0 immediately; ia←1 after dtime_a cycles.
  - dt_onoff=1, raw 1→0: ia←0 immediately; ib←1 after dtime_b cycles.
  - dtime=0 means zero added delay.
  - raw toggles while a delay is pending: cancel the pending rise, restart the counter for the opposite edge. ia and ib are never both 1.
  - pwm_onoff=0: ia=ib=0, counter cleared.
- Output stage: pwmout_a = logic_a_active ? ia : ~ia; same for b.
- Fault handling:
  - fault_latched sets on the clock edge after fault=1.
  - While it is set: ia=ib=0, raw=0, counters cleared. Outputs are inactive the cycle after fault_latched rises.
  - Clears on a cycle with fault_clr=1 and fault=0. fault=1 has priority over fault_clr.
  - Shadow loading continues during a fault.
- Reset, including mid-operation: all registers return to their reset values. Outputs become 0 asynchronously (logic reset to 1, ia=ib=0); fault_latched=0; load_ack=0.

## Timing
- Carrier/compare-active change to pwmout with dt_onoff=0: 2 cycles (raw register, then ia/ib register).
- Input compare change to pwmout with pwm_onoff=0: 3 cycles.
- With pwm_onoff=1, maskevent in cycle t: the new active value is used by the comparator from t+1, and pwmout reflects it at t+3.
- Dead-time rising edges are delayed a further dtime cycles. Falling edges have no added delay.
- fault=1 at cycle t: fault_latched=1 at t+1, outputs inactive at t+2.
- fault_clr: fault_latched=0 one cycle later. PWM resumes from the next raw evaluation.
- maskevent and fault in the same cycle: both take effect.

## Test plan
- Reset, NCH=3, 16-bit: hold reset, then release. All pwmout=0, fault_latched=0, load_ack=0. Asserting reset mid-PWM returns the outputs to 0 asynchronously.
- Shadowing: pwm_onoff=1, active cmp=100; write compare=200 without maskevent and check the duty is still based on 100. Pulse maskevent and check load_ack one cycle later and the new threshold at t+3.
- Dead time: dtime_a=5, dtime_b=3, carrier ramp 0..999, cmp=500.
  - pwmout_b falls at the raw rise and pwmout_a rises 5 cycles later.
  - pwmout_a falls at the raw fall and pwmout_b rises 3 cycles later.
  - ia and ib are never both 1.
- Short pulse: raw high for 2 cycles with dtime_a=5. pwmout_a never rises, and pwmout_b rises dtime_b cycles after raw falls.
- Carrier select and polarity: channel 1 carrsel=1 tracks carrier_master. logic_b=0 inverts pwmout_b, and the inactive level is 1.
- Fault: fault=1 for one cycle mid-pulse gives outputs inactive 2 cycles later. fault_clr held together with fault=1 does not clear. fault_clr with fault=0 clears, and PWM resumes.
